// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcode constants, ALU
// operation codes, control-bundle bit positions and the decoded bundle type.
package decode_pkg;

  // Major opcodes recognised by the decoder.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // ALU operation codes; 1100-1111 belong to the M extension.
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1100;
  localparam logic [3:0] ALU_MULH  = 4'b1101;
  localparam logic [3:0] ALU_DIV   = 4'b1110;
  localparam logic [3:0] ALU_REM   = 4'b1111;

  // Control bundle layout: {RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg, Branch, Jump, Illegal}.
  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_JUMP     = 1;
  localparam int CTRL_ILLEGAL  = 0;

  // Everything the decoder derives from one instruction word (RV32: 32-bit immediate).
  typedef struct packed {
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic [3:0]        aluctrl;
    logic [CTRL_W-1:0] ctrl;
    logic [2:0]        brfunc;
  } dec_bundle_t;

  // Base ALU operation selected by funct3 for R-type and I-ALU (shift-right defaults to logical).
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master: the surrounding pipeline (drives instructions, consumes bundles).
// slave:  the decode stage itself.
interface decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_aluctrl;
  logic [7:0]      out_ctrl;
  logic [2:0]      out_brfunc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_imm, out_aluctrl, out_ctrl, out_brfunc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
           out_imm, out_aluctrl, out_ctrl, out_brfunc
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I-subset decoder: instruction word -> control bundle.
// Optional feature: define DECODE_MULDIV_EN to decode MUL/MULH/DIV/REM
// (R-type funct7 0000001); otherwise that funct7 is an illegal instruction.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_bundle_t dec_o
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic        legal;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};

  // Map opcode/funct fields to the bundle; any illegal encoding collapses to a bare trap marker.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    dec_o = '0;
    legal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_o.rs1 = rs1;
        dec_o.rs2 = rs2;
        dec_o.rd  = rd;
        dec_o.ctrl[CTRL_REGWRITE] = 1'b1;
        case (funct7)
          7'b0000000: dec_o.aluctrl = alu_from_funct3(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec_o.aluctrl = ALU_SUB;
            else if (funct3 == 3'b101) dec_o.aluctrl = ALU_SRA;
            else                       legal = 1'b0;
          end
`ifdef DECODE_MULDIV_EN
          7'b0000001: begin
            case (funct3)
              3'b000:  dec_o.aluctrl = ALU_MUL;
              3'b001:  dec_o.aluctrl = ALU_MULH;
              3'b100:  dec_o.aluctrl = ALU_DIV;
              3'b110:  dec_o.aluctrl = ALU_REM;
              default: legal = 1'b0;
            endcase
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_o.rs1 = rs1;
        dec_o.rd  = rd;
        dec_o.imm = imm_i;
        dec_o.ctrl[CTRL_REGWRITE] = 1'b1;
        dec_o.ctrl[CTRL_ALUSRC]   = 1'b1;
        dec_o.aluctrl = alu_from_funct3(funct3);
        // Shift immediates encode the shift type in imm[11:5]; there is no subtract-immediate.
        if (funct3 == 3'b001 && funct7 != 7'b0000000) legal = 1'b0;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000)      dec_o.aluctrl = ALU_SRA;
          else if (funct7 != 7'b0000000) legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        dec_o.rs1     = rs1;
        dec_o.rd      = rd;
        dec_o.imm     = imm_i;
        dec_o.aluctrl = ALU_ADD;
        dec_o.ctrl[CTRL_REGWRITE] = 1'b1;
        dec_o.ctrl[CTRL_MEMREAD]  = 1'b1;
        dec_o.ctrl[CTRL_ALUSRC]   = 1'b1;
        dec_o.ctrl[CTRL_MEMTOREG] = 1'b1;
        if (funct3 != 3'b010) legal = 1'b0;
      end
      OPC_STORE: begin
        dec_o.rs1     = rs1;
        dec_o.rs2     = rs2;
        dec_o.imm     = imm_s;
        dec_o.aluctrl = ALU_ADD;
        dec_o.ctrl[CTRL_MEMWRITE] = 1'b1;
        dec_o.ctrl[CTRL_ALUSRC]   = 1'b1;
        if (funct3 != 3'b010) legal = 1'b0;
      end
      OPC_BRANCH: begin
        dec_o.rs1     = rs1;
        dec_o.rs2     = rs2;
        dec_o.imm     = imm_b;
        dec_o.aluctrl = ALU_SUB;
        dec_o.brfunc  = funct3;
        dec_o.ctrl[CTRL_BRANCH] = 1'b1;
        if (funct3[2:1] == 2'b01) legal = 1'b0;
      end
      OPC_JAL: begin
        dec_o.rd      = rd;
        dec_o.imm     = imm_j;
        dec_o.aluctrl = ALU_ADD;
        dec_o.ctrl[CTRL_REGWRITE] = 1'b1;
        dec_o.ctrl[CTRL_JUMP]     = 1'b1;
      end
      OPC_LUI: begin
        dec_o.rd      = rd;
        dec_o.imm     = imm_u;
        dec_o.aluctrl = ALU_PASSB;
        dec_o.ctrl[CTRL_REGWRITE] = 1'b1;
        dec_o.ctrl[CTRL_ALUSRC]   = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec_o = '0;
      dec_o.ctrl[CTRL_ILLEGAL] = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute. Decodes on the input
// side, then holds results in a two-entry buffer (OUT drives the outputs,
// SKID absorbs one instruction while OUT is stalled) so in_ready comes
// straight from a flop. flush kills both entries on the next edge.
// Optional feature: DECODE_MULDIV_EN (see decode_comb).
module decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  decode_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    dec_bundle_t     dec;
  } entry_t;

  dec_bundle_t in_dec;
  entry_t      in_entry;
  entry_t      out_q;
  entry_t      skid_q;
  logic        out_valid_q;
  logic        out_valid_d;
  logic        skid_valid_q;
  logic        skid_valid_d;
  logic        accept;
  logic        out_free;
  logic        load_out_new;
  logic        load_out_skid;
  logic        load_skid;

  decode_comb u_decode_comb (
    .instr_i (bus.in_instr),
    .dec_o   (in_dec)
  );

  assign in_entry = '{pc: bus.in_pc, dec: in_dec};
  assign accept   = bus.in_valid && !skid_valid_q && !flush;
  assign out_free = !out_valid_q || bus.out_ready;

  // Buffer control: SKID refills OUT first to keep FIFO order; flush overrides everything.
  always_comb begin
    out_valid_d   = out_valid_q;
    skid_valid_d  = skid_valid_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        load_out_skid = 1'b1;
        out_valid_d   = 1'b1;
        skid_valid_d  = 1'b0;
      end else if (accept) begin
        load_out_new = 1'b1;
        out_valid_d  = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // Valid flags and the OUT entry; OUT data only changes when a new entry loads.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '{pc: RESET_PC, dec: '0};
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      if (load_out_skid)     out_q <= skid_q;
      else if (load_out_new) out_q <= in_entry;
    end
  end

  // SKID payload capture while OUT is stalled.
  always_ff @(posedge clk) begin
    // NOTE: payload needs no reset; it is never observed unless skid_valid_q is set.
    if (load_skid) skid_q <= in_entry;
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_rs1     = out_q.dec.rs1;
  assign bus.out_rs2     = out_q.dec.rs2;
  assign bus.out_rd      = out_q.dec.rd;
  assign bus.out_imm     = XLEN'(out_q.dec.imm);
  assign bus.out_aluctrl = out_q.dec.aluctrl;
  assign bus.out_ctrl    = out_q.dec.ctrl;
  assign bus.out_brfunc  = out_q.dec.brfunc;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a scoreboard queue receives the
// expected bundle whenever an instruction is accepted and is compared when
// EX consumes a bundle. Expected decodes are hand-encoded constants.
module tb_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [7:0]  ctrl;
    logic [2:0]  brf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  decode_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  int          out_cnt      = 0;
  logic [31:0] next_pc;
  vec_t        drv_exp;
  vec_t        mon_e;
  vec_t        sb[$];
  vec_t        stream[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] instr,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm, input logic [3:0] alu,
                              input logic [7:0] ctrl, input logic [2:0] brf);
    vec_t v;
    v.name = n; v.instr = instr; v.pc = '0;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = imm;
    v.alu = alu; v.ctrl = ctrl; v.brf = brf;
    return v;
  endfunction

  // Scoreboard: push on accept, pop and compare on consume; flush discards everything held.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            mon_e = sb.pop_front();
            out_cnt++;
            check({"pc/", mon_e.name},     bus.out_pc,              mon_e.pc);
            check({"rs1/", mon_e.name},    32'(bus.out_rs1),        32'(mon_e.rs1));
            check({"rs2/", mon_e.name},    32'(bus.out_rs2),        32'(mon_e.rs2));
            check({"rd/", mon_e.name},     32'(bus.out_rd),         32'(mon_e.rd));
            check({"imm/", mon_e.name},    bus.out_imm,             mon_e.imm);
            check({"alu/", mon_e.name},    32'(bus.out_aluctrl),    32'(mon_e.alu));
            check({"ctrl/", mon_e.name},   32'(bus.out_ctrl),       32'(mon_e.ctrl));
            check({"brfunc/", mon_e.name}, 32'(bus.out_brfunc),     32'(mon_e.brf));
          end
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(drv_exp);
      end
    end
  end

  // Present one instruction from posedge+1 until it is accepted (bounded), ending at posedge+1.
  task automatic send(input vec_t v);
    int budget;
    v.pc = next_pc;
    next_pc += 32'd4;
    drv_exp = v;
    bus.in_valid = 1'b1;
    bus.in_instr = v.instr;
    bus.in_pc    = v.pc;
    budget = 20;
    forever begin
      @(negedge clk);
      if (bus.in_ready && !flush) break;
      budget--;
      if (budget == 0) begin
        check({"send_timeout/", v.name}, 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int budget;
    bus.in_valid = 1'b0;
    budget = 20;
    while ((sb.size() != 0 || bus.out_valid) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v_add, v_mul, a_v, b_v, c_v, d_v, g_v;
    int start, kept, cnt_before;
    logic [31:0] pc_a, imm_a;

    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    next_pc = 32'h0000_1000;
    kept = 0;

    v_add = mk("add", 32'h002081B3, 5'd1, 5'd2, 5'd3, 32'h0, 4'b0010, 8'h80, 3'b000);
`ifdef DECODE_MULDIV_EN
    v_mul = mk("mul", 32'h027302B3, 5'd6, 5'd7, 5'd5, 32'h0, 4'b1100, 8'h80, 3'b000);
`else
    v_mul = mk("mul", 32'h027302B3, 5'd0, 5'd0, 5'd0, 32'h0, 4'b0000, 8'h01, 3'b000);
`endif
    stream.push_back(mk("sub",     32'h407302B3, 5'd6,  5'd7, 5'd5,  32'h0,        4'b0110, 8'h80, 3'b000));
    stream.push_back(mk("srai",    32'h4045D513, 5'd11, 5'd0, 5'd10, 32'h00000404, 4'b1001, 8'h90, 3'b000));
    stream.push_back(mk("andi",    32'hFFF2F213, 5'd5,  5'd0, 5'd4,  32'hFFFFFFFF, 4'b0000, 8'h90, 3'b000));
    stream.push_back(mk("lw",      32'hFFC12403, 5'd2,  5'd0, 5'd8,  32'hFFFFFFFC, 4'b0010, 8'hD8, 3'b000));
    stream.push_back(mk("sw",      32'h00912423, 5'd2,  5'd9, 5'd0,  32'h00000008, 4'b0010, 8'h30, 3'b000));
    stream.push_back(mk("bne",     32'hFE209CE3, 5'd1,  5'd2, 5'd0,  32'hFFFFFFF8, 4'b0110, 8'h04, 3'b001));
    stream.push_back(mk("jal",     32'h010000EF, 5'd0,  5'd0, 5'd1,  32'h00000010, 4'b0010, 8'h82, 3'b000));
    stream.push_back(mk("lui",     32'hABCDE3B7, 5'd0,  5'd0, 5'd7,  32'hABCDE000, 4'b1010, 8'h90, 3'b000));
    stream.push_back(mk("zero",    32'h00000000, 5'd0,  5'd0, 5'd0,  32'h0,        4'b0000, 8'h01, 3'b000));
    stream.push_back(mk("br011",   32'hFE20BCE3, 5'd0,  5'd0, 5'd0,  32'h0,        4'b0000, 8'h01, 3'b000));
    stream.push_back(mk("slli_bad",32'h02109093, 5'd0,  5'd0, 5'd0,  32'h0,        4'b0000, 8'h01, 3'b000));
    stream.push_back(v_mul);

    // Reset state, checked while reset is asserted and right after release.
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_pc",    bus.out_pc,         RESET_PC);
    check("rst_out_imm",   bus.out_imm,        32'd0);
    check("rst_out_ctrl",  32'(bus.out_ctrl),  32'd0);
    check("rst_out_alu",   32'(bus.out_aluctrl), 32'd0);
    check("rst_out_rd",    32'(bus.out_rd),    32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_out_pc",    bus.out_pc,         RESET_PC);

    // Single instruction: visible one edge after acceptance.
    bus.out_ready = 1'b1;
    send(v_add);
    kept++;
    check("lat_out_valid", 32'(bus.out_valid),   32'd1);
    check("lat_alu",       32'(bus.out_aluctrl), 32'b0010);
    check("lat_ctrl",      32'(bus.out_ctrl),    32'h80);
    check("lat_rd",        32'(bus.out_rd),      32'd3);
    idle();
    drain();

    // Back-to-back stream with out_ready high: one accept per cycle.
    start = cyc;
    foreach (stream[i]) begin
      send(stream[i]);
      kept++;
    end
    check("stream_cycles", 32'(cyc - start), 32'(stream.size()));
    drain();

    // Stall: out_ready low for three cycles under continuous input.
    a_v = mk("stall_a", 32'h002081B3, 5'd1, 5'd2, 5'd3, 32'h0,        4'b0010, 8'h80, 3'b000);
    b_v = mk("stall_b", 32'h407302B3, 5'd6, 5'd7, 5'd5, 32'h0,        4'b0110, 8'h80, 3'b000);
    c_v = mk("stall_c", 32'hFFC12403, 5'd2, 5'd0, 5'd8, 32'hFFFFFFFC, 4'b0010, 8'hD8, 3'b000);
    d_v = mk("stall_d", 32'hABCDE3B7, 5'd0, 5'd0, 5'd7, 32'hABCDE000, 4'b1010, 8'h90, 3'b000);
    bus.out_ready = 1'b0;
    pc_a  = next_pc;
    imm_a = a_v.imm;
    send(a_v);
    check("stall_in_ready_1", 32'(bus.in_ready), 32'd1);
    send(b_v);
    check("stall_in_ready_0", 32'(bus.in_ready), 32'd0);
    check("stall_hold_pc",    bus.out_pc,        pc_a);
    c_v.pc = next_pc;
    drv_exp = c_v;
    bus.in_valid = 1'b1;
    bus.in_instr = c_v.instr;
    bus.in_pc    = c_v.pc;
    @(posedge clk); #1;
    check("stall_hold_pc_2",  bus.out_pc,        pc_a);
    check("stall_hold_imm",   bus.out_imm,       imm_a);
    check("stall_in_ready_2", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    send(c_v);
    send(d_v);
    kept += 4;
    drain();
    check("stall_out_count", 32'(out_cnt), 32'(kept));

    // Flush with OUT and SKID full while a new instruction is offered.
    bus.out_ready = 1'b0;
    send(mk("flush_e", 32'h00912423, 5'd2, 5'd9, 5'd0, 32'h8, 4'b0010, 8'h30, 3'b000));
    send(mk("flush_f", 32'h010000EF, 5'd0, 5'd0, 5'd1, 32'h10, 4'b0010, 8'h82, 3'b000));
    check("pre_flush_in_ready", 32'(bus.in_ready), 32'd0);
    g_v = mk("flush_g", 32'h002081B3, 5'd1, 5'd2, 5'd3, 32'h0, 4'b0010, 8'h80, 3'b000);
    g_v.pc = next_pc;
    drv_exp = g_v;
    bus.in_valid = 1'b1;
    bus.in_instr = g_v.instr;
    bus.in_pc    = g_v.pc;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready",  32'(bus.in_ready),  32'd1);
    cnt_before = out_cnt;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("flush_no_emit", 32'(out_cnt), 32'(cnt_before));

    // Recovery after flush.
    send(mk("post_flush", 32'hFE209CE3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 4'b0110, 8'h04, 3'b001));
    kept++;
    drain();

    check("final_sb_empty",  32'(sb.size()), 32'd0);
    check("final_out_count", 32'(out_cnt),   32'(kept));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
